// File: rtl/regfile_dbg.sv
// Debug access port for a 32 x 32-bit register file: single read, single write and full dump.
// Optional macro REGDBG_WRITE_ECHO_EN adds a read-back response after every write.
module regfile_dbg (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_re,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        busy
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;

    // NOP holds the single idle-equivalent cycle that follows a reserved op.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DUMP = 3'd3,
        RSP  = 3'd4,
        NOP  = 3'd5
`ifdef REGDBG_WRITE_ECHO_EN
        , WRB = 3'd6
`endif
    } state_t;

    state_t      state;
    logic [4:0]  addr_lat;
    logic [5:0]  dump_cnt;

    // Command sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_lat  <= 5'd0;
            dump_cnt  <= 6'd0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= 5'd0;
            rsp_data  <= 32'd0;
            rsp_last  <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            rf_re     <= 1'b0;
            rf_raddr  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_lat  <= cmd_addr;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (cmd_op)
                            OP_READ: begin
                                state    <= RD;
                                rf_re    <= 1'b1;
                                rf_raddr <= cmd_addr;
                            end
                            OP_WRITE: begin
                                state    <= WR;
                                rf_we    <= 1'b1;
                                rf_waddr <= cmd_addr;
                                rf_wdata <= cmd_wdata;
                            end
                            OP_DUMP: begin
                                state    <= DUMP;
                                dump_cnt <= 6'd0;
                                rf_re    <= 1'b1;
                                rf_raddr <= 5'd0;
                            end
                            default: begin
                                state <= NOP;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end

                RD: begin
                    state     <= RSP;
                    rf_re     <= 1'b0;
                    rf_raddr  <= 5'd0;
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_lat;
                    rsp_data  <= rf_rdata;
                    rsp_last  <= 1'b1;
                end

                WR: begin
                    rf_we    <= 1'b0;
                    rf_waddr <= 5'd0;
                    rf_wdata <= 32'd0;
`ifdef REGDBG_WRITE_ECHO_EN
                    state    <= WRB;
                    rf_re    <= 1'b1;
                    rf_raddr <= addr_lat;
`else
                    state     <= IDLE;
                    addr_lat  <= 5'd0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
`endif
                end

`ifdef REGDBG_WRITE_ECHO_EN
                WRB: begin
                    state     <= RSP;
                    rf_re     <= 1'b0;
                    rf_raddr  <= 5'd0;
                    rsp_valid <= 1'b1;
                    rsp_addr  <= addr_lat;
                    rsp_data  <= rf_rdata;
                    rsp_last  <= 1'b1;
                end
`endif

                DUMP: begin
                    state     <= RSP;
                    rf_re     <= 1'b0;
                    rf_raddr  <= 5'd0;
                    rsp_valid <= 1'b1;
                    rsp_addr  <= dump_cnt[4:0];
                    rsp_data  <= rf_rdata;
                    rsp_last  <= (dump_cnt == 6'd31);
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_addr  <= 5'd0;
                        rsp_data  <= 32'd0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            state     <= IDLE;
                            addr_lat  <= 5'd0;
                            dump_cnt  <= 6'd0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            // Counter saturates at 31 rather than wrapping back to 0.
                            state <= DUMP;
                            rf_re <= 1'b1;
                            if (dump_cnt == 6'd31) begin
                                dump_cnt <= dump_cnt;
                                rf_raddr <= dump_cnt[4:0];
                            end else begin
                                dump_cnt <= dump_cnt + 6'd1;
                                rf_raddr <= dump_cnt[4:0] + 5'd1;
                            end
                        end
                    end else begin
                        state <= RSP;
                    end
                end

                NOP: begin
                    state     <= IDLE;
                    addr_lat  <= 5'd0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    addr_lat  <= 5'd0;
                    dump_cnt  <= 6'd0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_addr  <= 5'd0;
                    rsp_data  <= 32'd0;
                    rsp_last  <= 1'b0;
                    rf_we     <= 1'b0;
                    rf_waddr  <= 5'd0;
                    rf_wdata  <= 32'd0;
                    rf_re     <= 1'b0;
                    rf_raddr  <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_dbg.md
REGFILE_DBG -- requirements
Module: regfile_dbg

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high (1 = reset asserted at the clk edge).
REQ-003 cmd_valid  input  1  host command present.
REQ-004 cmd_ready  output  1  block can accept a command.
REQ-005 cmd_op  input  2  00 read, 01 write, 10 dump, 11 reserved.
REQ-006 cmd_addr  input  5  target register address (read/write only).
REQ-007 cmd_wdata  input  32  write data.
REQ-008 rsp_valid  output  1  response word present.
REQ-009 rsp_ready  input  1  host accepts response.
REQ-010 rsp_addr  output  5  register address of response word.
REQ-011 rsp_data  output  32  register contents.
REQ-012 rsp_last  output  1  final word of the current command.
REQ-013 rf_we / rf_waddr / rf_wdata  output  1/5/32  register-file write port drive.
REQ-014 rf_re / rf_raddr  output  1/5  register-file read port drive.
REQ-015 rf_rdata  input  32  register-file read data, combinational in the same cycle as rf_re/rf_raddr.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, RD, WR, WRB (configured only), DUMP, RSP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, and op/addr/wdata are latched at that edge.
REQ-019 Read: accepted at edge T; RD during cycle T..T+1 drives rf_re=1, rf_raddr=addr; at edge T+1 rf_rdata is captured and the block enters RSP with rsp_valid=1, rsp_addr=addr, rsp_last=1.
REQ-020 Write: WR for exactly one cycle after acceptance drives rf_we=1, rf_waddr=addr, rf_wdata=wdata; without the configured feature the block then returns to IDLE with no response.
REQ-021 Dump: the block SHALL emit 32 responses for addresses 0..31 in ascending order; each is one DUMP read cycle followed by RSP; rsp_last=1 only on address 31; cmd_addr is ignored.
REQ-022 Address 0 SHALL be read like any other address; the returned value is whatever rf_rdata supplies (0 from the register file).
REQ-023 Reserved op 11 SHALL be accepted, produce no port activity and no response, and return to IDLE on the next edge.
REQ-024 In RSP, rsp_valid/rsp_addr/rsp_data/rsp_last SHALL hold stable until rsp_ready=1; on that edge the block goes to IDLE (last word) or to DUMP with address+1.
REQ-025 rsp_ready=1 while rsp_valid=0 SHALL have no effect.
REQ-026 rf_we and rf_re SHALL never be 1 in the same cycle; rf_we SHALL be 1 only in WR; rf_re SHALL be 1 only in RD, WRB and DUMP.
REQ-027 When not active, rf_waddr, rf_wdata and rf_raddr SHALL be 0.
REQ-028 Dump address counter SHALL be 6 bits and stop at 31 with no wrap to 0.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE and clear the latched command and dump counter, with all outputs 0 after that edge except cmd_ready=1, including mid-dump or while rsp_valid=1 (the pending word is dropped).
REQ-030 While rst=1, cmd_valid SHALL be ignored; the first acceptance can occur at the first edge with rst=0.

Configuration
REQ-031 Macro REGDBG_WRITE_ECHO_EN: when defined, WR SHALL be followed by one WRB cycle that reads back addr; the block then enters RSP with rsp_data = read-back value and rsp_last=1. When undefined, WRB does not exist and writes produce no response (REQ-020).

Verification
REQ-032 Write op=01 addr=5 wdata=32'hDEADBEEF, then read addr=5 -> one rf_we pulse with waddr=5; the read responds rsp_addr=5, rsp_data=32'hDEADBEEF, rsp_last=1.
REQ-033 Read addr=0 -> rsp_data=32'h00000000, and cmd_ready stays 0 until the response is taken.
REQ-034 Dump with rsp_ready held 0 for 3 cycles on word 7 -> word 7 stable for those cycles; 32 words total, addresses 0..31 in order, rsp_last only on 31.
REQ-035 rst asserted while the dump is at word 12 -> after the edge: rsp_valid=0, busy=0, cmd_ready=1; a new read then works normally.
REQ-036 Op 11 -> no rf_we/rf_re activity, no response, cmd_ready=1 two edges after acceptance.
REQ-037 With REGDBG_WRITE_ECHO_EN defined, write addr=18 data=32'h00000FFF -> rf_we pulse, then rf_re with raddr=18, then a response with rsp_data=32'h00000FFF and rsp_last=1; with the macro undefined -> no response.
